// File: rtl/alu_mul_seq.sv
// Shift-add multiplier sequencer: drives the shared ALU with one ADD per multiplier bit
// and returns the low WIDTH bits of a*b with {N,Z,C,V} flags.
module alu_mul_seq #(
  parameter int unsigned WIDTH      = 32,
  parameter bit          EARLY_EXIT = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [3:0]       out_flags,
  output logic             alu_req,
  input  logic             alu_gnt,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_control,
  input  logic [WIDTH-1:0] alu_result
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             res_valid_q, res_valid_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [3:0]       flags_q, flags_d;
  logic             last_iter;

  // Final iteration: all bits consumed, or no set bits remain above the current one.
  assign last_iter = (count_q == CntLast) || (EARLY_EXIT && ((mplier_q >> 1) == '0));

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    count_d     = count_q;
    res_valid_d = res_valid_q;
    res_d       = res_q;
    flags_d     = flags_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          mcand_d  = in_a;
          mplier_d = in_b;
          acc_d    = '0;
          count_d  = '0;
          state_d  = StRun;
        end
      end
      StRun: begin
        // Without a grant nothing moves.
        if (alu_gnt) begin
          if (mplier_q[0]) acc_d = alu_result;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          count_d  = count_q + CntW'(1);
          if (last_iter) state_d = StDone;
        end
      end
      StDone: begin
        // First DONE cycle registers the result; it is then held until accepted.
        if (!res_valid_q) begin
          res_valid_d = 1'b1;
          res_d       = acc_q;
          flags_d     = {acc_q[WIDTH-1], (acc_q == '0), 2'b00};
        end else if (out_ready) begin
          res_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      count_q     <= '0;
      res_valid_q <= 1'b0;
      res_q       <= '0;
      flags_q     <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      count_q     <= count_d;
      res_valid_q <= res_valid_d;
      res_q       <= res_d;
      flags_q     <= flags_d;
    end
  end

  assign in_ready    = (state_q == StIdle);
  assign alu_req     = (state_q == StRun);
  assign out_valid   = res_valid_q;
  assign out_result  = res_q;
  assign out_flags   = flags_q;
  assign alu_a       = acc_q;
  assign alu_b       = mcand_q;
  assign alu_control = 3'b000;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Directed scoreboard bench for alu_mul_seq; one instance per EARLY_EXIT setting,
// each paired with a behavioural adder standing in for the shared ALU.
module tb_alu_mul_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid1, in_valid0, out_ready, alu_gnt, sel;
  logic [31:0] in_a, in_b;

  logic        in_ready1, out_valid1, alu_req1;
  logic [31:0] out_result1, alu_a1, alu_b1, alu_result1;
  logic [3:0]  out_flags1;
  logic [2:0]  alu_control1;
  logic        in_ready0, out_valid0, alu_req0;
  logic [31:0] out_result0, alu_a0, alu_b0, alu_result0;
  logic [3:0]  out_flags0;
  logic [2:0]  alu_control0;

  assign alu_result1 = alu_a1 + alu_b1;
  assign alu_result0 = alu_a0 + alu_b0;

  alu_mul_seq #(.WIDTH(32), .EARLY_EXIT(1'b1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid1), .in_ready(in_ready1), .in_a(in_a),
    .in_b(in_b), .out_valid(out_valid1), .out_ready(out_ready), .out_result(out_result1),
    .out_flags(out_flags1), .alu_req(alu_req1), .alu_gnt(alu_gnt), .alu_a(alu_a1),
    .alu_b(alu_b1), .alu_control(alu_control1), .alu_result(alu_result1)
  );

  alu_mul_seq #(.WIDTH(32), .EARLY_EXIT(1'b0)) dut_full (
    .clk(clk), .reset(reset), .in_valid(in_valid0), .in_ready(in_ready0), .in_a(in_a),
    .in_b(in_b), .out_valid(out_valid0), .out_ready(out_ready), .out_result(out_result0),
    .out_flags(out_flags0), .alu_req(alu_req0), .alu_gnt(alu_gnt), .alu_a(alu_a0),
    .alu_b(alu_b0), .alu_control(alu_control0), .alu_result(alu_result0)
  );

  logic        in_ready_s, out_valid_s, alu_req_s;
  logic [31:0] out_result_s, alu_a_s, alu_b_s;
  logic [3:0]  out_flags_s;
  logic [2:0]  alu_control_s;
  assign in_ready_s    = sel ? in_ready0 : in_ready1;
  assign out_valid_s   = sel ? out_valid0 : out_valid1;
  assign alu_req_s     = sel ? alu_req0 : alu_req1;
  assign out_result_s  = sel ? out_result0 : out_result1;
  assign alu_a_s       = sel ? alu_a0 : alu_a1;
  assign alu_b_s       = sel ? alu_b0 : alu_b1;
  assign out_flags_s   = sel ? out_flags0 : out_flags1;
  assign alu_control_s = sel ? alu_control0 : alu_control1;

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic [3:0]  flags;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   nchk = 0;
  int   npass = 0;
  int   nfail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int run_cycles(input logic [31:0] b, input bit early);
    int h;
    if (!early) return 32;
    h = 0;
    for (int i = 0; i < 32; i++) if (b[i]) h = i;
    return h + 1;
  endfunction

  // One multiply: optional grant gap of stall_len cycles starting stall_at edges after
  // accept, and hold cycles of out_ready=0 once the result is up.
  task automatic op(input logic [31:0] a, input logic [31:0] b, input bit use_full,
                    input int stall_at, input int stall_len, input int hold,
                    input string tag);
    exp_t        e;
    logic [31:0] pa, pb, r;
    logic [3:0]  f;
    int          edges;
    bit          done;
    e.res   = a * b;
    e.flags = {e.res[31], (e.res == 32'd0), 2'b00};
    e.lat   = run_cycles(b, !use_full) + 1 + stall_len;
    sb.push_back(e);
    sel       = use_full;
    out_ready = (hold == 0);
    alu_gnt   = 1'b1;
    #1;
    check({tag, "/in_ready_idle"}, in_ready_s, 1);
    in_a = a;
    in_b = b;
    if (use_full) in_valid0 = 1'b1;
    else in_valid1 = 1'b1;
    @(posedge clk);
    #1;
    in_valid0 = 1'b0;
    in_valid1 = 1'b0;
    edges = 0;
    done  = 1'b0;
    while (!done && edges < 300) begin
      alu_gnt = !(edges >= stall_at && edges < stall_at + stall_len);
      pa = alu_a_s;
      pb = alu_b_s;
      if (!alu_gnt) check({tag, "/stall_req"}, alu_req_s, 1);
      @(posedge clk);
      edges++;
      #1;
      if (!alu_gnt) begin
        check({tag, "/stall_acc"}, alu_a_s, pa);
        check({tag, "/stall_mcand"}, alu_b_s, pb);
      end
      if (out_valid_s) done = 1'b1;
    end
    alu_gnt = 1'b1;
    check({tag, "/out_valid_seen"}, done, 1);
    if (done) begin
      e = sb.pop_front();
      check({tag, "/latency"}, edges, e.lat);
      check({tag, "/result"}, out_result_s, e.res);
      check({tag, "/flags"}, out_flags_s, e.flags);
      check({tag, "/in_ready_done"}, in_ready_s, 0);
      check({tag, "/alu_req_done"}, alu_req_s, 0);
      r = out_result_s;
      f = out_flags_s;
      repeat (hold) begin
        @(posedge clk);
        #1;
        check({tag, "/hold_valid"}, out_valid_s, 1);
        check({tag, "/hold_result"}, out_result_s, r);
        check({tag, "/hold_flags"}, out_flags_s, f);
        check({tag, "/hold_in_ready"}, in_ready_s, 0);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      check({tag, "/valid_fall"}, out_valid_s, 0);
      check({tag, "/in_ready_back"}, in_ready_s, 1);
    end else begin
      sb.delete();
    end
  endtask

  initial begin
    reset     = 1'b1;
    in_valid1 = 1'b0;
    in_valid0 = 1'b0;
    alu_gnt   = 1'b0;
    out_ready = 1'b1;
    in_a      = '0;
    in_b      = '0;
    sel       = 1'b0;
    #2;
    check("reset/in_ready", in_ready_s, 1);
    check("reset/out_valid", out_valid_s, 0);
    check("reset/alu_req", alu_req_s, 0);
    check("reset/out_result", out_result_s, 0);
    check("reset/out_flags", out_flags_s, 0);
    check("reset/alu_control", alu_control_s, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;

    op(32'd7, 32'd6, 1'b0, 0, 0, 0, "basic_7x6");
    op(32'hFFFF_FFFD, 32'd5, 1'b0, 0, 0, 0, "signed_wrap");
    op(32'h0001_0000, 32'h0001_0000, 1'b0, 0, 0, 0, "truncate_zero");
    op(32'h0000_1234, 32'd0, 1'b0, 0, 0, 0, "mul_by_zero");
    op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0, 0, 0, "full_length");
    op(32'hDEAD_BEEF, 32'd1, 1'b1, 0, 0, 0, "no_early_exit_b1");
    op(32'd7, 32'd6, 1'b1, 0, 0, 0, "no_early_exit_7x6");
    op(32'd7, 32'd6, 1'b0, 1, 4, 5, "stall_backpressure");

    // Abort an operation in its second RUN cycle.
    sel = 1'b0;
    alu_gnt = 1'b1;
    in_a = 32'd7;
    in_b = 32'd6;
    in_valid1 = 1'b1;
    @(posedge clk);
    #1;
    in_valid1 = 1'b0;
    @(posedge clk);
    #1;
    check("abort/running", alu_req_s, 1);
    reset = 1'b1;
    #1;
    check("abort/out_valid", out_valid_s, 0);
    check("abort/in_ready", in_ready_s, 1);
    check("abort/alu_req", alu_req_s, 0);
    check("abort/acc_cleared", alu_a_s, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      check("abort/no_spurious_valid", out_valid_s, 0);
    end
    op(32'd3, 32'd3, 1'b0, 0, 0, 0, "after_abort_3x3");

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
